// File: rtl/led_field_scan.sv
// led_field_scan
// Time-multiplexed 7-segment driver for the clock/calendar display. Each of
// N_FIELDS packed 7-bit binary fields is shown as two digits on one shared
// segment bus. Fields are converted to BCD one at a time by a sequential
// shift-add-3 engine at the start of each units slot; the tens slot that
// follows reuses the same result.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   enable_display 0 blanks segments and digit enables (scan keeps running)
//   cnt_bus        field f at bits [7f+6:7f], unsigned binary
//   blink_sel      per-field blink enable
//   seg            segments g..a at bits 6..0, polarity per SEG_ACTIVE_LOW
//   dig_sel        one-hot digit enable; bit 2f = units, bit 2f+1 = tens
//   frame_done     one-cycle pulse in the last cycle of the last digit slot
//
// Build option:
//   LED_LEADING_ZERO_BLANK_EN  when defined, values 0..9 show a blank tens
//                              digit instead of "0".

module led_field_scan #(
    parameter int N_FIELDS       = 7,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_DIV      = 25000000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_display,
    input  logic [7*N_FIELDS-1:0]   cnt_bus,
    input  logic [N_FIELDS-1:0]     blink_sel,
    output logic [6:0]              seg,
    output logic [2*N_FIELDS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int DIG_N = 2 * N_FIELDS;
    localparam int D_W   = $clog2(DIG_N);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [D_W-1:0]   D_LAST    = D_W'(DIG_N - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(9);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    localparam logic [6:0]       SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIG_N-1:0] DIG_OFF = (SEG_ACTIVE_LOW != 0) ? {DIG_N{1'b1}} : {DIG_N{1'b0}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // conv layout: [18:15] hundreds, [14:11] tens, [10:7] units, [6:0] binary
    function automatic logic [18:0] dd_step(input logic [18:0] v);
        logic [18:0] t;
        t = v;
        if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        if (t[18:15] >= 4'd5) t[18:15] = t[18:15] + 4'd3;
        return {t[17:0], 1'b0};
    endfunction

    // {dash, tens, units}; dash marks values of 100 and above
    function automatic logic [8:0] bcd_result(input logic [18:0] v);
        return {(v[18:15] != 4'd0), v[14:11], v[10:7]};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [D_W-1:0]   d_q, d_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             phase_q, phase_d;
    logic [1:0]       state_q, state_d;
    logic [2:0]       sh_cnt_q, sh_cnt_d;
    logic [18:0]      conv_q, conv_d;
    logic [8:0]       disp_q, disp_d;
    logic [6:0]       seg_q, seg_d;
    logic [DIG_N-1:0] dig_q, dig_d;
    logic             frame_q, frame_d;

    logic [6:0]       cap_val;
    logic [8:0]       view;
    logic             blink_bit;
    logic             show;
    logic [3:0]       digit;
    logic [6:0]       pat;
    logic [DIG_N-1:0] onehot;

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        d_d       = d_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            d_d       = (d_q == D_LAST) ? '0 : d_q + 1'b1;
        end

        blk_cnt_d = blk_cnt_q + 1'b1;
        phase_d   = phase_q;
        if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d = '0;
            phase_d   = ~phase_q;
        end
    end

    always_comb begin
        cap_val = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if ((d_q >> 1) == D_W'(i)) cap_val = cnt_bus[7*i +: 7];
        end

        state_d  = state_q;
        sh_cnt_d = sh_cnt_q;
        conv_d   = conv_q;
        disp_d   = disp_q;
        case (state_q)
            S_IDLE: begin
                if (div_cnt_q == '0 && !d_q[0]) state_d = S_LOAD;
            end
            S_LOAD: begin
                conv_d   = {12'd0, cap_val};
                sh_cnt_d = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                conv_d   = dd_step(conv_q);
                sh_cnt_d = sh_cnt_q + 1'b1;
                if (sh_cnt_q == 3'd6) state_d = S_DONE;
            end
            default: begin
                disp_d  = bcd_result(conv_q);
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-cycle state so that what appears on the
    // pins lines up with the slot counters. The finished conversion is
    // forwarded straight from the engine for the two cycles before it lands
    // in disp_q, so the digit lights exactly at div_cnt = 9.
    always_comb begin
        view = disp_q;
        if (state_d == S_DONE || state_q == S_DONE) view = bcd_result(conv_d);

        blink_bit = 1'b0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if ((d_d >> 1) == D_W'(i)) blink_bit = blink_sel[i];
        end

        digit = d_d[0] ? view[7:4] : view[3:0];
        pat   = view[8] ? 7'h40 : glyph(digit);
`ifdef LED_LEADING_ZERO_BLANK_EN
        if (!view[8] && d_d[0] && view[7:4] == 4'd0) pat = 7'h00;
`endif
        if (blink_bit && !phase_d) pat = 7'h00;

        // Even slots stay dark until the new conversion is ready (anti-ghosting)
        show   = enable_display && (d_d[0] || div_cnt_d >= BLANK_END);
        onehot = DIG_N'(1) << d_d;

        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        if (show) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
            dig_d = (SEG_ACTIVE_LOW != 0) ? ~onehot : onehot;
        end

        frame_d = (d_d == D_LAST) && (div_cnt_d == DIV_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            d_q       <= '0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b1;
            state_q   <= S_IDLE;
            sh_cnt_q  <= '0;
            conv_q    <= '0;
            disp_q    <= 9'h0FF;  // tens/units code 15 decodes to blank
            seg_q     <= SEG_OFF;
            dig_q     <= DIG_OFF;
            frame_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            d_q       <= d_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
            state_q   <= state_d;
            sh_cnt_q  <= sh_cnt_d;
            conv_q    <= conv_d;
            disp_q    <= disp_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            frame_q   <= frame_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_led_field_scan.sv
// Bench for led_field_scan: two fields, 16-clock slots, 40-clock blink.
// An active-low and an active-high instance share all inputs.
module tb_led_field_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [13:0] cnt = {7'd7, 7'd42};
    logic [1:0]  blink = 2'b00;
    logic [6:0]  seg_l, seg_h;
    logic [3:0]  dig_l, dig_h;
    logic        fd_l, fd_h;

    int n_tests = 0;
    int n_fail  = 0;
    int cur     = 0;

    // active-low glyphs
    localparam logic [6:0] G0 = 7'h40, G2 = 7'h24, G4 = 7'h19, G5 = 7'h12;
    localparam logic [6:0] G7 = 7'h78, G9 = 7'h10, GD = 7'h3F, OFF = 7'h7F;
`ifdef LED_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] T07 = 7'h7F;
`else
    localparam logic [6:0] T07 = 7'h40;
`endif

    always #5 clk = ~clk;

    led_field_scan #(.N_FIELDS(2), .SCAN_DIV(16), .BLINK_DIV(40), .SEG_ACTIVE_LOW(1)) u_dut_l (
        .clk(clk), .rst(rst), .enable_display(en), .cnt_bus(cnt), .blink_sel(blink),
        .seg(seg_l), .dig_sel(dig_l), .frame_done(fd_l));

    led_field_scan #(.N_FIELDS(2), .SCAN_DIV(16), .BLINK_DIV(40), .SEG_ACTIVE_LOW(0)) u_dut_h (
        .clk(clk), .rst(rst), .enable_display(en), .cnt_bus(cnt), .blink_sel(blink),
        .seg(seg_h), .dig_sel(dig_h), .frame_done(fd_h));

    // cycle 0 is the interval between reset release and the first rising edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cur = 0;
        #1;
    endtask

    task automatic go_to(input int k);
        while (cur < k) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if ({seg_l, dig_l, fd_l} !== {OFF, 4'hF, 1'b0}) begin n_fail++;
            $display("FAIL rst_low seg/dig/fd=%h/%b/%b exp %h/1111/0", seg_l, dig_l, fd_l, OFF); end
        n_tests++; if ({seg_h, dig_h, fd_h} !== {7'h00, 4'h0, 1'b0}) begin n_fail++;
            $display("FAIL rst_high seg/dig/fd=%h/%b/%b exp 00/0000/0", seg_h, dig_h, fd_h); end
        rst = 1'b0; cur = 0;
        go_to(20);
        n_tests++; if ({seg_l, dig_l} !== {G4, 4'b1101}) begin n_fail++;
            $display("FAIL rst_pre seg/dig=%h/%b exp %h/1101", seg_l, dig_l, G4); end
        rst = 1'b1;
        #1;
        n_tests++; if ({seg_l, dig_l, fd_l} !== {OFF, 4'hF, 1'b0}) begin n_fail++;
            $display("FAIL rst_async seg/dig/fd=%h/%b/%b exp %h/1111/0", seg_l, dig_l, fd_l, OFF); end
    endtask

    task automatic test_decode();
        int pulses;
        cnt = {7'd7, 7'd42}; blink = 2'b00; en = 1'b1;
        do_reset();
        go_to(5);
        n_tests++; if ({seg_l, dig_l} !== {OFF, 4'hF}) begin n_fail++;
            $display("FAIL dec_blank5 seg/dig=%h/%b exp %h/1111", seg_l, dig_l, OFF); end
        go_to(8);
        n_tests++; if ({seg_l, dig_l} !== {OFF, 4'hF}) begin n_fail++;
            $display("FAIL dec_blank8 seg/dig=%h/%b exp %h/1111", seg_l, dig_l, OFF); end
        go_to(9);
        n_tests++; if ({seg_l, dig_l} !== {G2, 4'b1110}) begin n_fail++;
            $display("FAIL dec_u0 seg/dig=%h/%b exp %h/1110", seg_l, dig_l, G2); end
        n_tests++; if ({seg_h, dig_h} !== {7'h5B, 4'b0001}) begin n_fail++;
            $display("FAIL pol_u0 seg/dig=%h/%b exp 5b/0001", seg_h, dig_h); end
        go_to(16);
        n_tests++; if ({seg_l, dig_l} !== {G4, 4'b1101}) begin n_fail++;
            $display("FAIL dec_t0 seg/dig=%h/%b exp %h/1101", seg_l, dig_l, G4); end
        n_tests++; if ({seg_h, dig_h} !== {7'h66, 4'b0010}) begin n_fail++;
            $display("FAIL pol_t0 seg/dig=%h/%b exp 66/0010", seg_h, dig_h); end
        go_to(40);
        n_tests++; if (dig_l !== 4'hF) begin n_fail++;
            $display("FAIL dec_blank40 dig=%b exp 1111", dig_l); end
        go_to(41);
        n_tests++; if ({seg_l, dig_l} !== {G7, 4'b1011}) begin n_fail++;
            $display("FAIL dec_u1 seg/dig=%h/%b exp %h/1011", seg_l, dig_l, G7); end
        go_to(48);
        n_tests++; if ({seg_l, dig_l} !== {T07, 4'b0111}) begin n_fail++;
            $display("FAIL dec_t1 seg/dig=%h/%b exp %h/0111", seg_l, dig_l, T07); end
        go_to(62);
        n_tests++; if (fd_l !== 1'b0) begin n_fail++;
            $display("FAIL fd_62 fd=%b exp 0", fd_l); end
        go_to(63);
        n_tests++; if ({fd_l, fd_h} !== 2'b11) begin n_fail++;
            $display("FAIL fd_63 fd=%b%b exp 11", fd_l, fd_h); end
        pulses = 0;
        for (int k = 64; k < 128; k++) begin
            go_to(k);
            if (fd_l) pulses++;
        end
        n_tests++; if (pulses != 1) begin n_fail++;
            $display("FAIL fd_count pulses=%0d exp 1", pulses); end
    endtask

    task automatic test_capture();
        cnt = {7'd7, 7'd42}; blink = 2'b00; en = 1'b1;
        do_reset();
        go_to(20);
        cnt[6:0] = 7'd59;
        go_to(24);
        n_tests++; if ({seg_l, dig_l} !== {G4, 4'b1101}) begin n_fail++;
            $display("FAIL cap_hold seg/dig=%h/%b exp %h/1101", seg_l, dig_l, G4); end
        go_to(66);
        cnt[6:0] = 7'd11;
        go_to(70);
        n_tests++; if (dig_l !== 4'hF) begin n_fail++;
            $display("FAIL cap_blank dig=%b exp 1111", dig_l); end
        go_to(73);
        n_tests++; if ({seg_l, dig_l} !== {G9, 4'b1110}) begin n_fail++;
            $display("FAIL cap_u seg/dig=%h/%b exp %h/1110", seg_l, dig_l, G9); end
        go_to(80);
        n_tests++; if ({seg_l, dig_l} !== {G5, 4'b1101}) begin n_fail++;
            $display("FAIL cap_t seg/dig=%h/%b exp %h/1101", seg_l, dig_l, G5); end
    endtask

    task automatic test_range();
        logic [6:0] vals [3];
        logic [6:0] exp_u [3];
        logic [6:0] exp_t [3];
        vals  = '{7'd100, 7'd127, 7'd99};
        exp_u = '{GD, GD, G9};
        exp_t = '{GD, GD, G9};
        blink = 2'b00; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cnt = {7'd7, vals[i]};
            do_reset();
            go_to(9);
            n_tests++; if ({seg_l, dig_l} !== {exp_u[i], 4'b1110}) begin n_fail++;
                $display("FAIL range_u val=%0d seg/dig=%h/%b exp %h/1110", vals[i], seg_l, dig_l, exp_u[i]); end
            go_to(16);
            n_tests++; if ({seg_l, dig_l} !== {exp_t[i], 4'b1101}) begin n_fail++;
                $display("FAIL range_t val=%0d seg/dig=%h/%b exp %h/1101", vals[i], seg_l, dig_l, exp_t[i]); end
        end
    endtask

    task automatic test_blink();
        cnt = {7'd7, 7'd42}; blink = 2'b01; en = 1'b1;
        do_reset();
        go_to(12);
        n_tests++; if ({seg_l, dig_l} !== {G2, 4'b1110}) begin n_fail++;
            $display("FAIL blink_on_u seg/dig=%h/%b exp %h/1110", seg_l, dig_l, G2); end
        go_to(20);
        n_tests++; if ({seg_l, dig_l} !== {G4, 4'b1101}) begin n_fail++;
            $display("FAIL blink_on_t seg/dig=%h/%b exp %h/1101", seg_l, dig_l, G4); end
        go_to(44);
        n_tests++; if ({seg_l, dig_l} !== {G7, 4'b1011}) begin n_fail++;
            $display("FAIL blink_f1 seg/dig=%h/%b exp %h/1011", seg_l, dig_l, G7); end
        go_to(75);
        n_tests++; if ({seg_l, dig_l} !== {OFF, 4'b1110}) begin n_fail++;
            $display("FAIL blink_off_u seg/dig=%h/%b exp %h/1110", seg_l, dig_l, OFF); end
        go_to(82);
        n_tests++; if ({seg_l, dig_l} !== {G4, 4'b1101}) begin n_fail++;
            $display("FAIL blink_on2 seg/dig=%h/%b exp %h/1101", seg_l, dig_l, G4); end
        go_to(150);
        n_tests++; if ({seg_l, dig_l} !== {OFF, 4'b1101}) begin n_fail++;
            $display("FAIL blink_off_t seg/dig=%h/%b exp %h/1101", seg_l, dig_l, OFF); end
        blink = 2'b00;
    endtask

    task automatic test_enable();
        cnt = {7'd7, 7'd42}; blink = 2'b00; en = 1'b1;
        do_reset();
        go_to(20);
        en = 1'b0;
        go_to(21);
        n_tests++; if ({seg_l, dig_l} !== {OFF, 4'hF}) begin n_fail++;
            $display("FAIL en_off_l seg/dig=%h/%b exp %h/1111", seg_l, dig_l, OFF); end
        n_tests++; if ({seg_h, dig_h} !== {7'h00, 4'h0}) begin n_fail++;
            $display("FAIL en_off_h seg/dig=%h/%b exp 00/0000", seg_h, dig_h); end
        go_to(30);
        n_tests++; if ({seg_l, dig_l} !== {OFF, 4'hF}) begin n_fail++;
            $display("FAIL en_off30 seg/dig=%h/%b exp %h/1111", seg_l, dig_l, OFF); end
        go_to(40);
        en = 1'b1;
        go_to(41);
        n_tests++; if ({seg_l, dig_l} !== {G7, 4'b1011}) begin n_fail++;
            $display("FAIL en_resume seg/dig=%h/%b exp %h/1011", seg_l, dig_l, G7); end
        n_tests++; if ({seg_h, dig_h} !== {7'h07, 4'b0100}) begin n_fail++;
            $display("FAIL en_resume_h seg/dig=%h/%b exp 07/0100", seg_h, dig_h); end
    endtask

    task automatic test_reset_mid();
        cnt = {7'd7, 7'd42}; blink = 2'b00; en = 1'b1;
        do_reset();
        go_to(36);
        cnt[6:0] = 7'd99;
        rst = 1'b1;
        #1;
        n_tests++; if ({seg_l, dig_l, fd_l} !== {OFF, 4'hF, 1'b0}) begin n_fail++;
            $display("FAIL mid_rst seg/dig/fd=%h/%b/%b exp %h/1111/0", seg_l, dig_l, fd_l, OFF); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cur = 0;
        go_to(8);
        n_tests++; if ({seg_l, dig_l} !== {OFF, 4'hF}) begin n_fail++;
            $display("FAIL mid_blank8 seg/dig=%h/%b exp %h/1111", seg_l, dig_l, OFF); end
        go_to(9);
        n_tests++; if ({seg_l, dig_l} !== {G9, 4'b1110}) begin n_fail++;
            $display("FAIL mid_first seg/dig=%h/%b exp %h/1110", seg_l, dig_l, G9); end
        go_to(16);
        n_tests++; if ({seg_l, dig_l} !== {G9, 4'b1101}) begin n_fail++;
            $display("FAIL mid_tens seg/dig=%h/%b exp %h/1101", seg_l, dig_l, G9); end
        go_to(48);
        n_tests++; if ({seg_l, dig_l} !== {T07, 4'b0111}) begin n_fail++;
            $display("FAIL mid_t1 seg/dig=%h/%b exp %h/0111", seg_l, dig_l, T07); end
        go_to(63);
        n_tests++; if (fd_l !== 1'b1) begin n_fail++;
            $display("FAIL mid_fd fd=%b exp 1", fd_l); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_capture();
        test_range();
        test_blink();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_field_scan.md
Name: led_field_scan

Overview:
- Time-multiplexed 7-segment driver for the clock/calendar display: takes N_FIELDS packed 7-bit field values (seconds, minutes, hours, day, month, year halves) and scans them onto one shared segment bus, two digits per field.
- Each field is converted binary-to-BCD by a sequential shift-add-3 engine; fields can blink individually for time-setting mode.
- Sits between the time/date counters and the board segment/digit pins, replacing per-field static decoders.

Parameters:
- N_FIELDS, 7, number of 2-digit fields; digit count is 2*N_FIELDS.
- SCAN_DIV, 1000, clocks per digit slot; legal range is >= 16.
- BLINK_DIV, 25000000, clocks per blink half-period; legal range is >= 2.
- SEG_ACTIVE_LOW, 1, when 1 a lit segment drives 0 and dig_sel is active-low; when 0 both are active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable_display  in  1  0 blanks all segments and digits; scanning continues.
- cnt_bus  in  7*N_FIELDS  field f occupies bits [7f+6:7f]; unsigned binary.
- blink_sel  in  N_FIELDS  1 = field blinks.
- seg  out  7  segments g..a at bits 6..0, polarity set by SEG_ACTIVE_LOW.
- dig_sel  out  2*N_FIELDS  one-hot digit enable; bit 2f = units of field f, bit 2f+1 = tens of field f.
- frame_done  out  1  one-cycle pulse at the end of the last digit slot.

Behaviour:
- Reset (async assert, sync release) values:
  - seg = all segments off; dig_sel = all off; frame_done = 0.
  - div_cnt = 0; digit index d = 0; blink phase = ON; conversion engine IDLE.
  - Reset asserted mid-conversion aborts the conversion; no partial result is ever displayed.
- Slot timing:
  - div_cnt counts 0..SCAN_DIV-1, then wraps to 0 and d advances; d wraps from 2*N_FIELDS-1 to 0.
  - frame_done = 1 only in the cycle where d = 2*N_FIELDS-1 and div_cnt = SCAN_DIV-1.
- Conversion FSM, states IDLE -> LOAD -> SHIFT -> DONE -> IDLE:
  - Trigger: even d with div_cnt = 0. In LOAD, capture field f = d/2 from cnt_bus and clear the BCD register.
  - SHIFT runs exactly 7 cycles of add-3-if-nibble>=5 followed by a left shift.
  - DONE latches tens/units into the display register, then returns to IDLE.
  - Latency: trigger to valid result is 9 clocks. dig_sel is all off for div_cnt 0..8 of every even slot (anti-ghosting), then enables digit d.
  - Odd slots reuse the latched result with no new conversion; dig_sel is enabled from div_cnt = 0.
  - cnt_bus changes outside LOAD have no effect until the next capture of that field.
- Value rules:
  - Value 0..99: units and tens digits decoded to the standard 0-9 glyphs.
  - Value 100..127: both digits show a dash (segment g only).
- Blink:
  - Blink phase toggles every BLINK_DIV clocks, free-running and independent of scan.
  - When blink phase is OFF and blink_sel[f] = 1, both digits of field f show segments off, but dig_sel still scans normally.
- enable_display = 0: seg = all off and dig_sel = all off on the next clock. Counters, FSM and blink keep running. Re-enable takes effect on the next clock with no resync.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: LED_LEADING_ZERO_BLANK_EN.
- Defined: when the captured value is 0..9, the tens digit shows all segments off instead of "0".
- Undefined: the tens digit always shows its decoded value, e.g. 5 displays "05".
- The dash rule for 100..127 is unchanged either way.

Test Plan:
- Basic decode: N_FIELDS=2, SCAN_DIV=16, cnt_bus field0=42, field1=7 -> slot0 units "2", slot1 tens "4", slot2 units "7", slot3 tens "0" (blank if macro defined); frame_done pulses once every 64 clocks.
- Conversion latency and blanking: check dig_sel = 0 for div_cnt 0..8 of even slots, and seg correct from div_cnt = 9. Change field0 from 42 to 59 mid-slot1 -> display stays 42 until the next slot0 capture, then shows 59.
- Out-of-range: field0=100 and field0=127 -> both digits show segment g only; 99 -> "99".
- Blink: BLINK_DIV=40, blink_sel=2'b01 -> field0 digits alternate between decoded and all-off every 40 clocks; field1 is unaffected; dig_sel scanning continues throughout.
- Enable and polarity: drop enable_display for 20 clocks -> seg and dig_sel all off one clock later, and the scan position continues advancing; repeat with SEG_ACTIVE_LOW=0 to check inverted levels.
- Reset mid-operation: assert rst during the SHIFT state -> seg and dig_sel immediately all off; after release, d = 0, div_cnt = 0, and the first valid digit appears at clock 9.
